my_rr_mux: RTL and testbench

Parametrised N-way, W-bit registered multiplexer with valid/ready handshaking on every input channel and on the output. It selects either the channel named by `sel` (fixed mode) or the next valid channel in round-robin order (arbitrated mode), and registers the chosen word together with its channel index. It is the sequential successor to the combinational `my_mux4way16` and sits wherever several 16-bit producers share one consumer.

---
 rtl/my_rr_mux_if.sv | 24 ++
 rtl/my_rr_mux.sv | 55 +++++
 tb/tb_my_rr_mux.sv | 104 ++++++++++
 3 files changed

// File: rtl/my_rr_mux_if.sv
// my_rr_mux_if: channel and output handshake bundle for my_rr_mux
interface my_rr_mux_if #(
    parameter int WIDTH = 16,
    parameter int WAYS  = 4,
    parameter int SEL_W = 2
);
    logic [WAYS*WIDTH-1:0] in_data;
    logic [WAYS-1:0]       in_valid;
    logic [WAYS-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_valid;
    logic                  out_ready;
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/my_rr_mux.sv
// my_rr_mux: registered N-way mux with fixed-select or round-robin grant and valid/ready handshake
module my_rr_mux #(
    parameter int WIDTH = 16,
    parameter int WAYS  = 4,
    parameter int SEL_W = 2
) (
    input  logic clk,
    input  logic reset,
    my_rr_mux_if.slave bus
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d, ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_idx, grant;
    logic             rr_hit, fx_hit, granted, load, xfer;
    // descending scan so the closest channel after ptr is written last and wins
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (bus.in_valid[(int'(ptr_q) + k) % WAYS]) begin
                rr_hit = 1'b1;
                rr_idx = SEL_W'((int'(ptr_q) + k) % WAYS);
            end
        end
    end
    always_comb begin
        fx_hit      = (int'(bus.sel) < WAYS) && bus.in_valid[bus.sel];
        grant       = bus.mode ? rr_idx : bus.sel;
        granted     = bus.mode ? rr_hit : fx_hit;
        load        = !out_valid_q || bus.out_ready;
        xfer        = load && granted;
        bus.in_ready = xfer ? (WAYS'(1) << grant) : '0;
        out_data_d  = xfer ? bus.in_data[int'(grant)*WIDTH +: WIDTH] : out_data_q;
        out_sel_d   = xfer ? grant : out_sel_q;
        out_valid_d = load ? xfer : out_valid_q;
        ptr_d       = !xfer ? ptr_q : (int'(grant) == WAYS - 1) ? '0 : grant + SEL_W'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_my_rr_mux.sv
// tb_my_rr_mux: directed vector bench for my_rr_mux with reset and backpressure sequences
module tb_my_rr_mux;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;
    my_rr_mux_if #(.WIDTH(16), .WAYS(4), .SEL_W(2)) bus ();
    my_rr_mux #(.WIDTH(16), .WAYS(4), .SEL_W(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  v;
        logic        ordy;
        logic [3:0]  ir;
        logic        ov;
        logic [15:0] d;
        logic [1:0]  s;
    } vec_t;
    vec_t vt[$];
    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask
    task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v, input logic o);
        bus.mode      = m;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.out_ready = o;
    endtask
    task automatic chk_out(input int idx, input logic ov, input logic [15:0] d, input logic [1:0] s);
        chk("out_valid", idx, 32'(bus.out_valid), 32'(ov));
        chk("out_data", idx, 32'(bus.out_data), 32'(d));
        chk("out_sel", idx, 32'(bus.out_sel), 32'(s));
    endtask
    initial begin
        // fixed sweep
        vt.push_back(vec_t'{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 16'h5555, 2'd0});
        vt.push_back(vec_t'{1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 16'hAAAA, 2'd1});
        vt.push_back(vec_t'{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 16'h00FF, 2'd2});
        vt.push_back(vec_t'{1'b0, 2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 16'hFF00, 2'd3});
        // round-robin, all valid, ptr wraps 3 -> 0
        vt.push_back(vec_t'{1'b1, 2'd3, 4'hF, 1'b1, 4'b0001, 1'b1, 16'h5555, 2'd0});
        vt.push_back(vec_t'{1'b1, 2'd3, 4'hF, 1'b1, 4'b0010, 1'b1, 16'hAAAA, 2'd1});
        vt.push_back(vec_t'{1'b1, 2'd3, 4'hF, 1'b1, 4'b0100, 1'b1, 16'h00FF, 2'd2});
        vt.push_back(vec_t'{1'b1, 2'd3, 4'hF, 1'b1, 4'b1000, 1'b1, 16'hFF00, 2'd3});
        vt.push_back(vec_t'{1'b1, 2'd3, 4'hF, 1'b1, 4'b0001, 1'b1, 16'h5555, 2'd0});
        vt.push_back(vec_t'{1'b1, 2'd3, 4'hF, 1'b1, 4'b0010, 1'b1, 16'hAAAA, 2'd1});
        // sparse round-robin, channels 1 and 3, ptr starts at 2
        vt.push_back(vec_t'{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 16'hFF00, 2'd3});
        vt.push_back(vec_t'{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 16'hAAAA, 2'd1});
        vt.push_back(vec_t'{1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 1'b1, 16'hFF00, 2'd3});
        vt.push_back(vec_t'{1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1'b1, 16'hAAAA, 2'd1});
        // fixed select of an idle channel drains the output
        vt.push_back(vec_t'{1'b0, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b0, 16'hAAAA, 2'd1});
        vt.push_back(vec_t'{1'b0, 2'd2, 4'hB, 1'b1, 4'b0000, 1'b0, 16'hAAAA, 2'd1});
        // backpressure: load 0x5555 then hold five cycles while mode/sel wander
        vt.push_back(vec_t'{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 16'h5555, 2'd0});
        vt.push_back(vec_t'{1'b0, 2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 16'h5555, 2'd0});
        vt.push_back(vec_t'{1'b1, 2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 16'h5555, 2'd0});
        vt.push_back(vec_t'{1'b0, 2'd3, 4'hF, 1'b0, 4'b0000, 1'b1, 16'h5555, 2'd0});
        vt.push_back(vec_t'{1'b0, 2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 16'h5555, 2'd0});
        vt.push_back(vec_t'{1'b0, 2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 16'h5555, 2'd0});
        vt.push_back(vec_t'{1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 16'hAAAA, 2'd1});
        bus.in_data = {16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555};
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_out(-1, 1'b0, 16'h0000, 2'd0);
        chk("in_ready_rst", -1, 32'(bus.in_ready), 32'h1);
        foreach (vt[i]) begin
            drive(vt[i].mode, vt[i].sel, vt[i].v, vt[i].ordy);
            #1;
            chk("in_ready", i, 32'(bus.in_ready), 32'(vt[i].ir));
            @(posedge clk);
            #1;
            chk_out(i, vt[i].ov, vt[i].d, vt[i].s);
        end
        // reset while a word is held under backpressure (ptr is 2 here)
        drive(1'b1, 2'd0, 4'hF, 1'b0);
        #1;
        chk("in_ready_hold", 100, 32'(bus.in_ready), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_out(100, 1'b0, 16'h0000, 2'd0);
        chk("in_ready_post_rst", 101, 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk_out(101, 1'b1, 16'h5555, 2'd0);
        // reset overrides a transfer that would otherwise happen
        drive(1'b1, 2'd0, 4'hF, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_out(102, 1'b0, 16'h0000, 2'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
